// File: rtl/mem_arbiter.sv
// Memory-side responder: arbitrates fetch and data ports onto one fixed-latency memory, data first.
// A miss stalls its port for MEM_LAT+1 cycles; results wait in per-port buffers until the pipeline advances.
module mem_arbiter #(
  parameter int MEM_LAT = 4,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rd_data,
  output logic              i_rdy,
  input  logic              d_re,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rd_data,
  output logic              d_rdy,
  output logic              mem_re,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

  typedef enum logic [1:0] {IDLE, D_BUSY, I_BUSY} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              mem_re_q, mem_re_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  logic              ibuf_vld_q, ibuf_vld_d;
  logic [ADDR_W-1:0] ibuf_addr_q, ibuf_addr_d;
  logic [DATA_W-1:0] ibuf_dat_q, ibuf_dat_d;
  logic              dbuf_vld_q, dbuf_vld_d;
  logic              dbuf_wr_q, dbuf_wr_d;
  logic [ADDR_W-1:0] dbuf_addr_q, dbuf_addr_d;
  logic [DATA_W-1:0] dbuf_dat_q, dbuf_dat_d;

  logic i_match, d_match, i_pend, d_pend, advance;

  always_comb begin
    i_match = ibuf_vld_q && (ibuf_addr_q == i_addr);
    d_match = dbuf_vld_q && (dbuf_addr_q == d_addr) && (dbuf_wr_q == d_we);
    i_pend  = i_re && !i_match;
    d_pend  = (d_re || d_we) && !d_match;
    i_rdy   = rst || !i_re || i_match;
    d_rdy   = rst || !(d_re || d_we) || d_match;
    advance = i_rdy && d_rdy;
  end

  assign i_rd_data = ibuf_dat_q;
  assign d_rd_data = dbuf_dat_q;
  assign mem_re    = mem_re_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_re_d    = mem_re_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    ibuf_vld_d  = ibuf_vld_q;
    ibuf_addr_d = ibuf_addr_q;
    ibuf_dat_d  = ibuf_dat_q;
    dbuf_vld_d  = dbuf_vld_q;
    dbuf_wr_d   = dbuf_wr_q;
    dbuf_addr_d = dbuf_addr_q;
    dbuf_dat_d  = dbuf_dat_q;

    // Consumption first so a same-cycle fill wins.
    if (advance) begin
      ibuf_vld_d = 1'b0;
      dbuf_vld_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (d_pend) begin
          state_d     = D_BUSY;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          mem_we_d    = d_we;
          mem_re_d    = !d_we;
          cnt_d       = CNT_LAST;
        end else if (i_pend) begin
          state_d    = I_BUSY;
          mem_addr_d = i_addr;
          mem_re_d   = 1'b1;
          mem_we_d   = 1'b0;
          cnt_d      = CNT_LAST;
        end
      end
      D_BUSY, I_BUSY: begin
        if (cnt_q == '0) begin
          if (state_q == D_BUSY) begin
            dbuf_vld_d  = 1'b1;
            dbuf_wr_d   = mem_we_q;
            dbuf_addr_d = mem_addr_q;
            dbuf_dat_d  = mem_we_q ? mem_wdata_q : mem_rdata;
          end else begin
            ibuf_vld_d  = 1'b1;
            ibuf_addr_d = mem_addr_q;
            ibuf_dat_d  = mem_rdata;
          end
          mem_re_d = 1'b0;
          mem_we_d = 1'b0;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      ibuf_vld_q  <= 1'b0;
      dbuf_vld_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_re_q    <= mem_re_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      ibuf_vld_q  <= ibuf_vld_d;
      dbuf_vld_q  <= dbuf_vld_d;
    end
  end

  // Buffer payloads are qualified by their valid bits, so they carry no reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ibuf_addr_q <= ibuf_addr_d;
      ibuf_dat_q  <= ibuf_dat_d;
      dbuf_wr_q   <= dbuf_wr_d;
      dbuf_addr_q <= dbuf_addr_d;
      dbuf_dat_q  <= dbuf_dat_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed timing sequences, a vector table, and random traffic
// checked against a timestamp-based transaction model.
module tb_mem_arbiter;
  localparam int MEM_LAT = 4;
  localparam int AW = 16;
  localparam int DW = 16;

  logic          clk, rst;
  logic          i_re, d_re, d_we;
  logic [AW-1:0] i_addr, d_addr, mem_addr;
  logic [DW-1:0] d_wdata, i_rd_data, d_rd_data, mem_wdata, mem_rdata;
  logic          i_rdy, d_rdy, mem_re, mem_we;
  logic          force_en;
  logic [DW-1:0] force_val;

  int n_chk, n_fail;

  mem_arbiter #(.MEM_LAT(MEM_LAT), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .i_re(i_re), .i_addr(i_addr), .i_rd_data(i_rd_data), .i_rdy(i_rdy),
    .d_re(d_re), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rd_data(d_rd_data), .d_rdy(d_rdy),
    .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [DW-1:0] mhash(input logic [AW-1:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5AC3;
  endfunction

  assign mem_rdata = force_en ? force_val : mhash(mem_addr);

  task automatic chk1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chkw(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h expected 0x%04h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic ire, input logic [15:0] ia,
                       input logic dre, input logic dwe, input logic [15:0] da,
                       input logic [15:0] dwd);
    rst = r; i_re = ire; i_addr = ia; d_re = dre; d_we = dwe; d_addr = da; d_wdata = dwd;
  endtask

  task automatic to_next();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
      to_next();
    end
  endtask

  function automatic logic [15:0] pick_addr();
    case ($urandom_range(3, 0))
      0:       return 16'h0010;
      1:       return 16'h0020;
      2:       return 16'h0100;
      default: return 16'h0200;
    endcase
  endfunction

  task automatic gen_req(output logic ire, output logic [15:0] ia, output logic dre,
                         output logic dwe, output logic [15:0] da, output logic [15:0] dwd);
    ire = ($urandom_range(3, 0) != 0);
    ia  = pick_addr();
    case ($urandom_range(3, 0))
      0:       begin dre = 1'b0; dwe = 1'b0; end
      1:       begin dre = 1'b1; dwe = 1'b0; end
      2:       begin dre = 1'b0; dwe = 1'b1; end
      default: begin dre = 1'b1; dwe = 1'b1; end
    endcase
    da  = pick_addr();
    dwd = 16'($urandom);
  endtask

  typedef struct {
    logic        i_re;
    logic [15:0] i_addr;
    logic        d_re;
    logic        d_we;
    logic [15:0] d_addr;
    logic        e_ir;
    logic        e_dr;
    logic        e_mre;
    logic        chk_a;
    logic [15:0] e_addr;
    logic        chk_d;
    logic [15:0] e_idat;
    logic [15:0] e_ddat;
  } vec_t;

  vec_t tbl[11];

  // Reference model: an access first seen idle at cycle c occupies memory until cycle c+MEM_LAT.
  bit          m_busy, m_port_d, m_wr;
  int          m_done, cyc;
  logic [15:0] m_addr, m_wd;
  bit          ib_v, db_v, db_w;
  logic [15:0] ib_a, ib_d, db_a, db_d;
  bit          im, dm, e_ir, e_dr;
  logic        g_rst, g_ire, g_dre, g_dwe;
  logic [15:0] g_ia, g_da, g_dwd;

  initial begin
    n_chk = 0; n_fail = 0;
    force_en = 1'b0; force_val = 16'h0;

    // Reset with a fetch request held high.
    drive(1'b1, 1'b1, 16'h0040, 1'b0, 1'b0, 16'h0, 16'h0);
    to_next();
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 1'b1, 16'h0040, 1'b0, 1'b0, 16'h0, 16'h0);
      @(negedge clk);
      chk1("rst_i_rdy", i_rdy, 1'b1);
      chk1("rst_d_rdy", d_rdy, 1'b1);
      chk1("rst_mem_re", mem_re, 1'b0);
      chk1("rst_mem_we", mem_we, 1'b0);
      to_next();
    end
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, 1'b1, 16'h0040, 1'b0, 1'b0, 16'h0, 16'h0);
      @(negedge clk);
      chk1("post_rst_i_rdy", i_rdy, 1'b0);
      chk1("post_rst_mem_re", mem_re, k == 1);
      if (k == 1) chkw("post_rst_mem_addr", mem_addr, 16'h0040);
      to_next();
    end
    idle(6);

    // Fetch-only with forced memory data.
    force_en = 1'b1; force_val = 16'hA5A5;
    for (int k = 0; k <= 6; k++) begin
      drive(1'b0, 1'b1, (k == 6) ? 16'h0014 : 16'h0010, 1'b0, 1'b0, 16'h0, 16'h0);
      @(negedge clk);
      chk1("fetch_i_rdy", i_rdy, k == 5);
      chk1("fetch_d_rdy", d_rdy, 1'b1);
      chk1("fetch_mem_re", mem_re, (k >= 1 && k <= 4));
      if (k >= 1 && k <= 4) chkw("fetch_mem_addr", mem_addr, 16'h0010);
      if (k == 5) chkw("fetch_i_rd_data", i_rd_data, 16'hA5A5);
      to_next();
    end
    idle(6);
    force_en = 1'b0;

    // Simultaneous fetch and load, table-driven.
    for (int k = 0; k < 11; k++) begin
      tbl[k].i_re   = 1'b1;
      tbl[k].i_addr = 16'h0020;
      tbl[k].d_re   = 1'b1;
      tbl[k].d_we   = 1'b0;
      tbl[k].d_addr = 16'h0100;
      tbl[k].e_ir   = (k == 10);
      tbl[k].e_dr   = (k >= 5);
      tbl[k].e_mre  = (k >= 1 && k <= 4) || (k >= 6 && k <= 9);
      tbl[k].chk_a  = tbl[k].e_mre;
      tbl[k].e_addr = (k < 5) ? 16'h0100 : 16'h0020;
      tbl[k].chk_d  = (k == 10);
      tbl[k].e_idat = mhash(16'h0020);
      tbl[k].e_ddat = mhash(16'h0100);
    end
    for (int k = 0; k < 11; k++) begin
      drive(1'b0, tbl[k].i_re, tbl[k].i_addr, tbl[k].d_re, tbl[k].d_we, tbl[k].d_addr, 16'h0);
      @(negedge clk);
      chk1("sim_i_rdy", i_rdy, tbl[k].e_ir);
      chk1("sim_d_rdy", d_rdy, tbl[k].e_dr);
      chk1("sim_mem_re", mem_re, tbl[k].e_mre);
      chk1("sim_mem_we", mem_we, 1'b0);
      if (tbl[k].chk_a) chkw("sim_mem_addr", mem_addr, tbl[k].e_addr);
      if (tbl[k].chk_d) begin
        chkw("sim_i_rd_data", i_rd_data, tbl[k].e_idat);
        chkw("sim_d_rd_data", d_rd_data, tbl[k].e_ddat);
      end
      to_next();
    end
    idle(2);

    // Store, then the same store again on the next instruction.
    for (int k = 0; k <= 7; k++) begin
      drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 16'h0200, 16'h1234);
      @(negedge clk);
      chk1("st_d_rdy", d_rdy, k == 5);
      chk1("st_mem_we", mem_we, (k >= 1 && k <= 4) || k == 7);
      chk1("st_mem_re", mem_re, 1'b0);
      if (k >= 1 && k <= 4) begin
        chkw("st_mem_wdata", mem_wdata, 16'h1234);
        chkw("st_mem_addr", mem_addr, 16'h0200);
      end
      to_next();
    end
    idle(6);

    // Reset in the middle of a fetch.
    for (int k = 0; k <= 8; k++) begin
      drive(k == 2, 1'b1, 16'h0030, 1'b0, 1'b0, 16'h0, 16'h0);
      @(negedge clk);
      chk1("mrst_i_rdy", i_rdy, k == 2 || k == 8);
      chk1("mrst_mem_re", mem_re, (k >= 1 && k <= 2) || (k >= 4 && k <= 7));
      if (k >= 4 && k <= 7) chkw("mrst_mem_addr", mem_addr, 16'h0030);
      if (k == 8) chkw("mrst_i_rd_data", i_rd_data, mhash(16'h0030));
      to_next();
    end
    idle(3);

    // Load withdrawn mid-access, then a load to another address.
    for (int k = 0; k <= 6; k++) begin
      drive(1'b0, 1'b0, 16'h0, (k < 2) || (k >= 5), 1'b0, (k >= 5) ? 16'h0044 : 16'h0040, 16'h0);
      @(negedge clk);
      chk1("wd_d_rdy", d_rdy, k >= 2 && k <= 4);
      chk1("wd_mem_re", mem_re, (k >= 1 && k <= 4) || k == 6);
      if (k == 5) chkw("wd_stale_data", d_rd_data, mhash(16'h0040));
      if (k == 6) chkw("wd_mem_addr", mem_addr, 16'h0044);
      to_next();
    end
    idle(8);

    // Random traffic against the model.
    m_busy = 0; m_port_d = 0; m_wr = 0; m_done = 0; cyc = 0;
    m_addr = 16'h0; m_wd = 16'h0;
    ib_v = 0; db_v = 0; db_w = 0; ib_a = 0; ib_d = 0; db_a = 0; db_d = 0;
    g_rst = 1'b1;
    gen_req(g_ire, g_ia, g_dre, g_dwe, g_da, g_dwd);
    for (int n = 0; n < 3000; n++) begin
      drive(g_rst, g_ire, g_ia, g_dre, g_dwe, g_da, g_dwd);
      @(negedge clk);
      im   = ib_v && (ib_a == g_ia);
      dm   = db_v && (db_a == g_da) && (db_w == g_dwe);
      e_ir = g_rst || !g_ire || im;
      e_dr = g_rst || !(g_dre || g_dwe) || dm;
      chk1("rnd_i_rdy", i_rdy, e_ir);
      chk1("rnd_d_rdy", d_rdy, e_dr);
      chk1("rnd_mem_re", mem_re, m_busy && !m_wr);
      chk1("rnd_mem_we", mem_we, m_busy && m_wr);
      if (m_busy) chkw("rnd_mem_addr", mem_addr, m_addr);
      if (m_busy && m_wr) chkw("rnd_mem_wdata", mem_wdata, m_wd);
      if (ib_v) chkw("rnd_i_rd_data", i_rd_data, ib_d);
      if (db_v) chkw("rnd_d_rd_data", d_rd_data, db_d);

      if (g_rst) begin
        m_busy = 0; ib_v = 0; db_v = 0;
      end else begin
        if (e_ir && e_dr) begin
          ib_v = 0; db_v = 0;
        end
        if (m_busy) begin
          if (cyc == m_done) begin
            if (m_port_d) begin
              db_v = 1; db_a = m_addr; db_w = m_wr; db_d = m_wr ? m_wd : mhash(m_addr);
            end else begin
              ib_v = 1; ib_a = m_addr; ib_d = mhash(m_addr);
            end
            m_busy = 0;
          end
        end else if ((g_dre || g_dwe) && !dm) begin
          m_busy = 1; m_port_d = 1; m_done = cyc + MEM_LAT;
          m_addr = g_da; m_wr = g_dwe; m_wd = g_dwd;
        end else if (g_ire && !im) begin
          m_busy = 1; m_port_d = 0; m_done = cyc + MEM_LAT;
          m_addr = g_ia; m_wr = 0;
        end
      end
      cyc++;

      if ((e_ir && e_dr) || $urandom_range(7, 0) == 0)
        gen_req(g_ire, g_ia, g_dre, g_dwe, g_da, g_dwd);
      g_rst = ($urandom_range(99, 0) == 0);
      to_next();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
